axis_frame_demux: RTL and testbench

// - 1-to-M_COUNT AXI-Stream frame demultiplexer; the fan-out counterpart of the N-to-1 axis_switch arbitration path.
// - Steers each whole frame from one slave port to a master port selected by s_axis_tdest on the frame's first beat.
// - Frames with out-of-range tdest are consumed and dropped. One output register stage; tid/tdest/tuser pass through.

---
 rtl/axis_frame_demux.sv | 173 +++++++++++++++++
 tb/tb_axis_frame_demux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_demux.sv
// axis_frame_demux: 1-to-M_COUNT AXI-Stream frame demultiplexer.
// The first beat's tdest selects the output port for the whole frame. Frames
// whose tdest is out of range are consumed and dropped. A single output
// register stage is shared by all ports; only the selected port sees tvalid.
module axis_frame_demux #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter bit ID_ENABLE   = 1'b1,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = $clog2(M_COUNT + 1),
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [ID_WIDTH-1:0]             s_axis_tid,
    input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,

    output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [M_COUNT-1:0]              m_axis_tvalid,
    input  logic [M_COUNT-1:0]              m_axis_tready,
    output logic [M_COUNT-1:0]              m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]     m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]   m_axis_tuser,

    output logic                            drop_frame
);

    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        frame_sel_q, frame_sel_d;
    logic [SEL_W-1:0]        out_sel_q, out_sel_d;
    logic                    out_valid_q, out_valid_d;
    logic                    drop_q, drop_d;

    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
    logic                    last_q, last_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;

    logic                    sel_ready;
    logic                    drain;
    logic                    accept;
    logic                    dest_ok;
    logic                    load;

    assign sel_ready     = m_axis_tready[out_sel_q];
    assign drain         = out_valid_q && sel_ready;
    // Dropped beats never touch the output register, so DROP can always sink.
    assign s_axis_tready = (state_q == DROP) ? 1'b1 : (!out_valid_q || sel_ready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign dest_ok       = (s_axis_tdest < DEST_WIDTH'(M_COUNT));

    // Frame FSM next state plus output-register load/drain decisions.
    always_comb begin
        state_d     = state_q;
        frame_sel_d = frame_sel_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        drop_d      = 1'b0;
        load        = 1'b0;
        dest_d      = dest_q;

        if (drain) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dest_ok) begin
                        load        = 1'b1;
                        frame_sel_d = s_axis_tdest[SEL_W-1:0];
                        out_sel_d   = s_axis_tdest[SEL_W-1:0];
                        dest_d      = s_axis_tdest;
                        if (!s_axis_tlast) state_d = ROUTE;
                    end else if (s_axis_tlast) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            ROUTE: begin
                // tdest of later beats is ignored; the frame stays on its port.
                if (accept) begin
                    load      = 1'b1;
                    out_sel_d = frame_sel_q;
                    if (s_axis_tlast) state_d = IDLE;
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load in the same cycle as a drain wins, keeping full throughput.
        if (load) begin
            out_valid_d = 1'b1;
        end

        data_d = load ? s_axis_tdata : data_q;
        keep_d = load ? s_axis_tkeep : keep_q;
        last_d = load ? s_axis_tlast : last_q;
        id_d   = load ? s_axis_tid   : id_q;
        user_d = load ? s_axis_tuser : user_q;
    end

    // Control state: FSM, port selects, valid and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_sel_q <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_sel_q <= frame_sel_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    // Payload register; contents only matter while out_valid_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
        last_q <= last_d;
        id_q   <= id_d;
        dest_q <= dest_d;
        user_q <= user_d;
    end

    // Every port sees the same register contents; tvalid picks the owner.
    for (genvar i = 0; i < M_COUNT; i++) begin : g_port
        assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = KEEP_ENABLE ? keep_q : {KEEP_WIDTH{1'b1}};
        assign m_axis_tvalid[i]                         = out_valid_q && (out_sel_q == SEL_W'(i));
        assign m_axis_tlast[i]                          = last_q;
        assign m_axis_tid[i*ID_WIDTH +: ID_WIDTH]       = ID_ENABLE ? id_q : {ID_WIDTH{1'b0}};
        assign m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] = dest_q;
        assign m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] = USER_ENABLE ? user_q : {USER_WIDTH{1'b0}};
    end

    assign drop_frame = drop_q;

endmodule

// File: tb/tb_axis_frame_demux.sv
// Scoreboard bench for axis_frame_demux (M_COUNT=4, 8-bit data).
module tb_axis_frame_demux;

    localparam int M   = 4;
    localparam int DW  = 8;
    localparam int KW  = 1;
    localparam int IW  = 8;
    localparam int DSW = 3;
    localparam int UW  = 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [DW-1:0]     s_axis_tdata;
    logic [KW-1:0]     s_axis_tkeep;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [IW-1:0]     s_axis_tid;
    logic [DSW-1:0]    s_axis_tdest;
    logic [UW-1:0]     s_axis_tuser;
    logic [M*DW-1:0]   m_axis_tdata;
    logic [M*KW-1:0]   m_axis_tkeep;
    logic [M-1:0]      m_axis_tvalid;
    logic [M-1:0]      m_axis_tready;
    logic [M-1:0]      m_axis_tlast;
    logic [M*IW-1:0]   m_axis_tid;
    logic [M*DSW-1:0]  m_axis_tdest;
    logic [M*UW-1:0]   m_axis_tuser;
    logic              drop_frame;

    always #5 clk = ~clk;

    axis_frame_demux #(
        .M_COUNT(M), .DATA_WIDTH(DW), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(KW),
        .ID_ENABLE(1'b1), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
        .USER_ENABLE(1'b1), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .drop_frame(drop_frame)
    );

    typedef struct {
        int             port;
        logic [DW-1:0]  data;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    beat_t sb[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    drops  = 0;
    int    p3_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor: pops the scoreboard on every completed m-side transfer.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (drop_frame)       drops++;
            if (m_axis_tvalid[3]) p3_cnt++;
            if (|m_axis_tvalid) chk("onehot", 64'($countones(m_axis_tvalid) <= 1), 1);
            for (int i = 0; i < M; i++) begin
                if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("port", i, e.port);
                        chk("data", m_axis_tdata[i*DW +: DW], e.data);
                        chk("last", m_axis_tlast[i], e.last);
                        chk("id",   m_axis_tid[i*IW +: IW], e.id);
                        chk("dest", m_axis_tdest[i*DSW +: DSW], e.dest);
                        chk("user", m_axis_tuser[i*UW +: UW], e.user);
                    end
                end
            end
        end
    end

    // Drive one beat, wait (bounded) for acceptance; port<0 means expect a drop.
    task automatic send(input logic [DW-1:0] d, input logic [DSW-1:0] dest,
                        input logic [IW-1:0] id, input logic last,
                        input int port, output int waited);
        beat_t e;
        s_axis_tdata  = d;
        s_axis_tkeep  = '1;
        s_axis_tdest  = dest;
        s_axis_tid    = id;
        s_axis_tlast  = last;
        s_axis_tuser  = d[0];
        s_axis_tvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_axis_tready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            chk("accept_timeout", waited, 0);
        end else if (port >= 0) begin
            e.port = port; e.data = d; e.last = last; e.id = id;
            e.dest = DSW'(port); e.user = d[0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int snap;
        s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
        m_axis_tready = 4'hF;

        // Power-up reset
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_drop", drop_frame, 0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", s_axis_tready, 1);
        idle(1);

        // Reset in the middle of a frame with a beat held in the register
        m_axis_tready = 4'h0;
        send(8'h77, 3'd2, 8'h01, 1'b0, -1, w);
        s_axis_tdata = 8'h78; s_axis_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_drop", drop_frame, 0);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 4'hF;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", s_axis_tready, 1);
        idle(1);

        // 3-beat frame to port 2
        send(8'h11, 3'd2, 8'h05, 1'b0, 2, w); chk("t2_w0", w, 0);
        chk("t2_vld0", m_axis_tvalid, 4'b0100);
        send(8'h22, 3'd2, 8'h05, 1'b0, 2, w); chk("t2_w1", w, 0);
        chk("t2_vld1", m_axis_tvalid, 4'b0100);
        send(8'h33, 3'd2, 8'h05, 1'b1, 2, w); chk("t2_w2", w, 0);
        chk("t2_vld2", m_axis_tvalid, 4'b0100);
        idle(2);

        // tdest changes mid-frame: frame stays on port 1
        snap = p3_cnt;
        send(8'hA1, 3'd1, 8'h07, 1'b0, 1, w);
        send(8'hA2, 3'd3, 8'h07, 1'b0, 1, w);
        send(8'hA3, 3'd3, 8'h07, 1'b1, 1, w);
        idle(2);
        chk("t3_p3_quiet", p3_cnt - snap, 0);

        // Out-of-range tdest: consumed, dropped, one pulse
        snap = drops;
        send(8'hD1, 3'd4, 8'h09, 1'b0, -1, w); chk("t4_rdy0", w, 0);
        m_axis_tready = 4'h0;
        send(8'hD2, 3'd4, 8'h09, 1'b1, -1, w); chk("t4_rdy1", w, 0);
        m_axis_tready = 4'hF;
        idle(3);
        chk("t4_drop_pulses", drops - snap, 1);

        // Back-to-back single-beat frames to every port
        for (int p = 0; p < M; p++) begin
            send(DW'(8'h50 + p), DSW'(p), IW'(p), 1'b1, p, w);
            chk("t5_wait", w, 0);
            chk("t5_vld", m_axis_tvalid, 64'(1) << p);
        end
        idle(2);

        // Backpressure on port 1 stalls the next frame and holds data
        m_axis_tready = 4'b1101;
        send(8'hAB, 3'd1, 8'h03, 1'b1, 1, w);
        s_axis_tdata = 8'hCD; s_axis_tdest = 3'd2; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_stall_rdy", s_axis_tready, 0);
            chk("t6_hold_data", m_axis_tdata[15:8], 8'hAB);
            chk("t6_hold_vld", m_axis_tvalid, 4'b0010);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 4'hF;
        send(8'hCD, 3'd2, 8'h03, 1'b1, 2, w);
        chk("t6_release", w, 0);
        idle(3);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
